// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, the fetch/memory pipeline ports
// and the single-ported unified memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_kill;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          stall_if;
    logic          stall_mem;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_valid,
        output d_rdata, d_valid,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr, if_kill,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_valid,
        input  d_rdata, d_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported unified memory, with data
// priority and a bounded starvation counter guaranteeing fetch progress.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_CONSEC = 4
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_D = 2'd1;
    localparam logic [1:0] S_BUSY_I = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] LP_MAX = 4'(MAX_CONSEC);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_kill;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_if_rdata;
    logic          r_if_valid;
    logic [DW-1:0] r_d_rdata;
    logic          r_d_valid;

    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_kill_now;
    logic [3:0]    w_cnt_inc;

    // Fetch wins only when data is idle or the starvation bound is hit.
    assign w_grant_i  = bus.if_req & (~bus.d_req | (r_cnt == LP_MAX));
    assign w_grant_d  = ~w_grant_i & bus.d_req;
    assign w_kill_now = r_kill | bus.if_kill;
    assign w_cnt_inc  = (r_cnt == LP_MAX) ? r_cnt : r_cnt + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_kill      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_d_rdata   <= '0;
            r_d_valid   <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    unique case (1'b1)
                        w_grant_i: begin
                            r_state     <= S_BUSY_I;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= bus.if_addr;
                            r_mem_wdata <= '0;
                            r_cnt       <= '0;
                            r_kill      <= bus.if_kill;
                        end
                        w_grant_d: begin
                            r_state     <= S_BUSY_D;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.d_we;
                            r_mem_addr  <= bus.d_addr;
                            r_mem_wdata <= bus.d_wdata;
                            r_cnt       <= bus.if_req ? w_cnt_inc : 4'd0;
                        end
                        default: ;
                    endcase
                end
                S_BUSY_D: begin
                    if (bus.mem_ack) begin
                        r_state   <= S_DONE;
                        r_mem_req <= 1'b0;
                        r_d_valid <= 1'b1;
                        if (!r_mem_we)
                            r_d_rdata <= bus.mem_rdata;
                    end
                end
                S_BUSY_I: begin
                    if (bus.if_kill)
                        r_kill <= 1'b1;
                    if (bus.mem_ack) begin
                        r_state   <= S_DONE;
                        r_mem_req <= 1'b0;
                        // A kill in the ack cycle still squashes the result.
                        if (!w_kill_now) begin
                            r_if_valid <= 1'b1;
                            r_if_rdata <= bus.mem_rdata;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_kill  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_valid  = r_if_valid;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_valid   = r_d_valid;
    assign bus.stall_if  = bus.if_req & ~r_if_valid;
    assign bus.stall_mem = bus.d_req & ~r_d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transactions push
// expected grants/read data, a negedge monitor pops and compares.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXC = 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } gnt_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_CONSEC(MAXC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    gnt_t        exp_g[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Memory model: fixed image, ack after lat cycles of mem_req.
    int lat       = 1;
    bit zero_wait = 1'b0;
    int wcnt      = 0;

    function automatic logic [31:0] img(input logic [31:0] a);
        case (a)
            32'h40:  return 32'hDEADBEEF;
            32'h100: return 32'h00000013;
            32'h200: return 32'h00000093;
            32'h300: return 32'h00100093;
            32'h304: return 32'h00200113;
            32'h400: return 32'h0BADF00D;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (zero_wait) begin
            bus.mem_ack = 1'b1;
        end else if (bus.mem_req) begin
            bus.mem_ack = (wcnt == lat - 1);
            wcnt++;
        end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end
        bus.mem_rdata = img(bus.mem_addr);
    end

    // Monitor: grants, request stability, and completion data.
    gnt_t cur;
    bit   cur_ok   = 1'b0;
    logic prev_req = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_req = 1'b0;
            cur_ok   = 1'b0;
        end else begin
            if (bus.mem_req && !prev_req) begin
                if (exp_g.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    cur_ok = 1'b0;
                    $display("FAIL grant: unexpected grant addr %h, none expected",
                             bus.mem_addr);
                end else begin
                    cur    = exp_g.pop_front();
                    cur_ok = 1'b1;
                    chk("grant_addr", bus.mem_addr, cur.addr);
                    chk("grant_we", 32'(bus.mem_we), 32'(cur.we));
                    chk("grant_wdata", bus.mem_wdata, cur.wdata);
                end
            end else if (bus.mem_req && cur_ok) begin
                chk("hold_addr", bus.mem_addr, cur.addr);
                chk("hold_we", 32'(bus.mem_we), 32'(cur.we));
                chk("hold_wdata", bus.mem_wdata, cur.wdata);
            end
            if (bus.d_valid) begin
                if (exp_d.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL d_valid: unexpected pulse, d_rdata %h", bus.d_rdata);
                end else begin
                    chk("d_rdata", bus.d_rdata, exp_d.pop_front());
                end
            end
            if (bus.if_valid) begin
                if (exp_i.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL if_valid: unexpected pulse, if_rdata %h", bus.if_rdata);
                end else begin
                    chk("if_rdata", bus.if_rdata, exp_i.pop_front());
                end
            end
            prev_req = bus.mem_req;
        end
    end

    task automatic data_xfer(input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input int l,
                             input logic [31:0] exp_rd);
        int n;
        bit got;
        @(posedge clk);
        #1;
        lat = l;
        exp_g.push_back('{addr: a, we: we, wdata: wd});
        exp_d.push_back(exp_rd);
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        n   = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.d_valid) got = 1'b1;
            else chk("stall_mem_wait", 32'(bus.stall_mem), 32'd1);
        end
        chk("d_valid_seen", 32'(got), 32'd1);
        chk("d_latency", 32'(n), 32'(l + 2));
        if (got) chk("stall_mem_valid", 32'(bus.stall_mem), 32'd0);
        @(negedge clk);
        chk("d_valid_once", 32'(bus.d_valid), 32'd0);
        #4;
        bus.d_req = 1'b0;
    endtask

    task automatic fetch_xfer(input logic [31:0] a, input int l,
                              input logic [31:0] exp_rd);
        int n;
        bit got;
        @(posedge clk);
        #1;
        lat = l;
        exp_g.push_back('{addr: a, we: 1'b0, wdata: 32'h0});
        exp_i.push_back(exp_rd);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        n   = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.if_valid) got = 1'b1;
            else chk("stall_if_wait", 32'(bus.stall_if), 32'd1);
        end
        chk("if_valid_seen", 32'(got), 32'd1);
        chk("if_latency", 32'(n), 32'(l + 2));
        if (got) chk("stall_if_valid", 32'(bus.stall_if), 32'd0);
        @(negedge clk);
        chk("if_valid_once", 32'(bus.if_valid), 32'd0);
        #4;
        bus.if_req = 1'b0;
    endtask

    initial begin
        int n;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_kill   = 1'b0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;

        #12;
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_d_valid", 32'(bus.d_valid), 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        #11;
        rst = 1'b1;

        // Single load, ack one cycle after mem_req.
        data_xfer(1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF);
        // Slow store: 5-cycle ack, d_rdata untouched.
        data_xfer(1'b1, 32'h80, 32'h55, 5, 32'hDEADBEEF);

        // Killed fetch at 0x100 followed by a fetch at 0x200.
        lat = 3;
        exp_g.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
        exp_g.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0});
        exp_i.push_back(32'h00000093);
        @(posedge clk);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.mem_req && n < 20);
        chk("kill_grant_seen", 32'(bus.mem_req), 32'd1);
        @(posedge clk);
        #1;
        bus.if_kill = 1'b1;
        bus.if_addr = 32'h200;
        @(posedge clk);
        #1;
        bus.if_kill = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (bus.mem_req && n < 20);
        chk("kill_no_valid", 32'(bus.if_valid), 32'd0);
        chk("kill_rdata_kept", bus.if_rdata, 32'h0);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.if_valid && n < 20);
        chk("kill_next_valid", 32'(bus.if_valid), 32'd1);
        chk("kill_next_rdata", bus.if_rdata, 32'h00000093);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;

        // Contention: expected grant order D,D,D,D,I,D,D,D,D,I.
        lat = 1;
        for (int k = 0; k < 8; k++) begin
            exp_g.push_back('{addr: 32'h1000 + 32'(4 * k), we: 1'b1, wdata: 32'(k)});
            exp_d.push_back(32'hDEADBEEF);
            if (k == 3)
                exp_g.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0});
        end
        exp_g.push_back('{addr: 32'h304, we: 1'b0, wdata: 32'h0});
        exp_i.push_back(32'h00100093);
        exp_i.push_back(32'h00200113);
        fork
            begin
                int m;
                @(posedge clk);
                #1;
                bus.d_req   = 1'b1;
                bus.d_we    = 1'b1;
                bus.d_addr  = 32'h1000;
                bus.d_wdata = 32'h0;
                for (int k = 0; k < 8; k++) begin
                    m = 0;
                    do begin @(negedge clk); m++; end while (!bus.d_valid && m < 100);
                    chk("cont_d_valid", 32'(bus.d_valid), 32'd1);
                    @(posedge clk);
                    #1;
                    if (k < 7) begin
                        bus.d_addr  = 32'h1000 + 32'(4 * (k + 1));
                        bus.d_wdata = 32'(k + 1);
                    end else begin
                        bus.d_req = 1'b0;
                    end
                end
            end
            begin
                int m;
                @(posedge clk);
                #1;
                bus.if_req  = 1'b1;
                bus.if_addr = 32'h300;
                for (int k = 0; k < 2; k++) begin
                    m = 0;
                    do begin @(negedge clk); m++; end while (!bus.if_valid && m < 100);
                    chk("cont_if_valid", 32'(bus.if_valid), 32'd1);
                    @(posedge clk);
                    #1;
                    if (k == 0) bus.if_addr = 32'h304;
                    else bus.if_req = 1'b0;
                end
            end
        join
        chk("cont_grants_done", 32'(exp_g.size()), 32'd0);

        // Zero-wait memory: ack tied high, 3-cycle transactions.
        zero_wait = 1'b1;
        data_xfer(1'b0, 32'h40, 32'h0, 1, 32'hDEADBEEF);
        fetch_xfer(32'h300, 1, 32'h00100093);
        repeat (4) @(posedge clk);
        zero_wait = 1'b0;
        repeat (2) @(posedge clk);

        // Reset during BUSY_I, then regrant of the still-pending fetch.
        lat = 20;
        exp_g.push_back('{addr: 32'h400, we: 1'b0, wdata: 32'h0});
        exp_g.push_back('{addr: 32'h400, we: 1'b0, wdata: 32'h0});
        exp_i.push_back(32'h0BADF00D);
        #1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h400;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("arst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("arst_mem_addr", bus.mem_addr, 32'h0);
        chk("arst_if_rdata", bus.if_rdata, 32'h0);
        chk("arst_d_rdata", bus.d_rdata, 32'h0);
        lat = 1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_regrant", 32'(bus.mem_req), 32'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.if_valid && n < 20);
        chk("arst_valid", 32'(bus.if_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        repeat (4) @(posedge clk);

        chk("exp_g_empty", 32'(exp_g.size()), 32'd0);
        chk("exp_i_empty", 32'(exp_i.size()), 32'd0);
        chk("exp_d_empty", 32'(exp_d.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
